// File: rtl/row_sequencer_if.sv
// Datapath-side bundle of the row sequencer: input-SRAM read port, MAC slice
// stream, MAC row result and output-SRAM write port.
interface row_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [191:0]      mem_rdata;
  logic              slice_valid;
  logic [47:0]       slice_data;
  logic              slice_last;
  logic              slice_ready;
  logic              res_valid;
  logic [23:0]       res_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;

  modport master (
    output mem_rd_en, mem_addr, input mem_rdata,
    output slice_valid, slice_data, slice_last, input slice_ready,
    input  res_valid, res_data,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, output mem_rdata,
    input  slice_valid, slice_data, slice_last, output slice_ready,
    output res_valid, res_data,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/row_sequencer.sv
// Job sequencer for the MAC datapath: fetch a 192-bit row, stream it as four
// 48-bit slices (MSB first), collect the 24-bit result, write it back.
module row_sequencer #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_rows,
  output logic              busy,
  output logic              done,
  output logic              err_unexp,
  row_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_RESULT, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] row_inc;
  logic [1:0]        k_q, k_d;
  logic [1:0]        lat_q, lat_d;
  logic [191:0]      rowbuf_q, rowbuf_d;
  logic [23:0]       res_q, res_d;
  logic              err_q, err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      num_q    <= '0;
      row_q    <= '0;
      k_q      <= '0;
      lat_q    <= '0;
      rowbuf_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      num_q    <= num_d;
      row_q    <= row_d;
      k_q      <= k_d;
      lat_q    <= lat_d;
      rowbuf_q <= rowbuf_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign row_inc = row_q + ADDR_W'(1);

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    num_d           = num_q;
    row_d           = row_q;
    k_d             = k_q;
    lat_d           = lat_q;
    rowbuf_d        = rowbuf_q;
    res_d           = res_q;
    // A result strobe anywhere but RESULT is a protocol error and is remembered.
    err_d           = err_q | (bus.res_valid && (state_q != S_RESULT));
    bus.mem_rd_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.slice_valid = 1'b0;
    bus.slice_data  = '0;
    bus.slice_last  = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    done            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          num_d   = num_rows;
          row_d   = '0;
          err_d   = bus.res_valid;
          state_d = (num_rows != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = base_q + row_q;
        lat_d         = 2'd1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == 2'(RD_LAT)) begin
          rowbuf_d = bus.mem_rdata;
          k_d      = 2'd0;
          state_d  = S_ISSUE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_ISSUE: begin
        bus.slice_valid = 1'b1;
        bus.slice_last  = (k_q == 2'd3);
        case (k_q)
          2'd0:    bus.slice_data = rowbuf_q[191:144];
          2'd1:    bus.slice_data = rowbuf_q[143:96];
          2'd2:    bus.slice_data = rowbuf_q[95:48];
          default: bus.slice_data = rowbuf_q[47:0];
        endcase
        if (bus.slice_ready) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (bus.res_valid) begin
          res_d   = bus.res_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = row_q;
        bus.wr_data = res_q;
        row_d       = row_inc;
        state_d     = (row_inc == num_q) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition; any read still in flight is dropped.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err_unexp = err_q;

endmodule

// File: tb/tb_row_sequencer.sv
// Scoreboard bench for row_sequencer: two instances (RD_LAT 1 and 2) sharing
// stimulus, with memory / MAC responders and an output monitor on the active one.
module tb_row_sequencer;
  localparam int AW = 8;
  localparam logic [191:0] JUNK = {4{48'hBAD0_BAD0_BAD0}};

  typedef struct packed {
    logic [47:0] d;
    logic        l;
  } sl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0, sel = 1'b0;
  logic [AW-1:0] base = '0, num = '0;
  logic          ready = 1'b1, res_valid = 1'b0;
  logic [23:0]   res_data = '0;
  logic [191:0]  rd1 = JUNK, rd2 = JUNK;
  logic          busy1, done1, err1, busy2, done2, err2;

  row_sequencer_if #(.ADDR_W(AW)) if1 ();
  row_sequencer_if #(.ADDR_W(AW)) if2 ();

  assign if1.mem_rdata   = rd1;
  assign if2.mem_rdata   = rd2;
  assign if1.slice_ready = ready;
  assign if2.slice_ready = ready;
  assign if1.res_valid   = res_valid & ~sel;
  assign if2.res_valid   = res_valid & sel;
  assign if1.res_data    = res_data;
  assign if2.res_data    = res_data;

  row_sequencer #(.ADDR_W(AW), .RD_LAT(1)) u1 (
    .clock(clk), .reset(rst), .start(start & ~sel), .abort(abort & ~sel),
    .base_addr(base), .num_rows(num), .busy(busy1), .done(done1),
    .err_unexp(err1), .bus(if1)
  );
  row_sequencer #(.ADDR_W(AW), .RD_LAT(2)) u2 (
    .clock(clk), .reset(rst), .start(start & sel), .abort(abort & sel),
    .base_addr(base), .num_rows(num), .busy(busy2), .done(done2),
    .err_unexp(err2), .bus(if2)
  );

  wire          m_busy = sel ? busy2 : busy1;
  wire          m_done = sel ? done2 : done1;
  wire          m_err  = sel ? err2 : err1;
  wire          m_rd   = sel ? if2.mem_rd_en : if1.mem_rd_en;
  wire [AW-1:0] m_addr = sel ? if2.mem_addr : if1.mem_addr;
  wire          m_sv   = sel ? if2.slice_valid : if1.slice_valid;
  wire [47:0]   m_sd   = sel ? if2.slice_data : if1.slice_data;
  wire          m_sl   = sel ? if2.slice_last : if1.slice_last;
  wire          m_wr   = sel ? if2.wr_en : if1.wr_en;
  wire [AW-1:0] m_wa   = sel ? if2.wr_addr : if1.wr_addr;
  wire [23:0]   m_wd   = sel ? if2.wr_data : if1.wr_data;
  wire [94:0]   m_all  = {m_busy, m_done, m_err, m_rd, m_addr, m_sv, m_sd, m_sl, m_wr, m_wa, m_wd};

  int nvec = 0, nerr = 0;
  int cyc = 0, t0 = 0;
  int rd_cyc = 0, wr_cyc = 0, done_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, hold_cnt = 0;
  int res_man_cyc = -1;
  bit auto_res = 1'b1, pend = 1'b0, sv_prev = 1'b0, hold_pend = 1'b0;
  logic [47:0] hold_d = '0;
  logic        hold_l = 1'b0;

  logic [AW-1:0] exp_addr[$];
  sl_t           exp_sl[$];
  logic [31:0]   exp_wr[$];
  logic [23:0]   res_tx[$];
  bit            rdy_q[$];
  int            hs_cyc[$];
  int            lat_obs[$];

  logic          p1v = 1'b0, q1v = 1'b0, q2v = 1'b0;
  logic [AW-1:0] p1a = '0, q1a = '0, q2a = '0;

  function automatic logic [191:0] pat(input logic [AW-1:0] a);
    if (a == 8'h10)
      return {48'h1111_1111_1111, 48'h2222_2222_2222, 48'h3333_3333_3333, 48'h4444_4444_4444};
    return {8'hEE, a, 8'h00, 24'h13579B, 8'hDD, a, 8'h01, 24'h2468AC,
            8'hCC, a, 8'h02, 24'hFEDCBA, 8'hBB, a, 8'h03, 24'h0F1E2D};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle: advance memory models, drive MAC-side inputs, then check outputs.
  always @(negedge clk) begin
    sl_t         es;
    logic [31:0] ew;
    rd1 = p1v ? pat(p1a) : JUNK;
    p1v = if1.mem_rd_en;  p1a = if1.mem_addr;
    rd2 = q2v ? pat(q2a) : JUNK;
    q2v = q1v;  q2a = q1a;
    q1v = if2.mem_rd_en;  q1a = if2.mem_addr;

    if (m_sv && rdy_q.size() > 0) ready = rdy_q.pop_front();
    else ready = 1'b1;
    res_valid = pend || (cyc == res_man_cyc);
    if (pend && res_tx.size() > 0) res_data = res_tx.pop_front();
    else res_data = 24'hEEEEEE;
    pend = 1'b0;

    if (m_rd) begin
      rd_cyc = cyc;  rd_cnt++;  nvec++;
      if (exp_addr.size() == 0) begin
        nerr++;  $display("FAIL rd_unexpected: got addr %h want no read", m_addr);
      end else begin
        logic [AW-1:0] ea;
        ea = exp_addr.pop_front();
        if (m_addr !== ea) begin
          nerr++;  $display("FAIL rd_addr: got %h want %h", m_addr, ea);
        end
      end
    end
    if (m_sv && !sv_prev) lat_obs.push_back(cyc - rd_cyc);
    sv_prev = m_sv;
    if (hold_pend) begin
      hold_cnt++;  nvec++;
      if ({m_sv, m_sd, m_sl} !== {1'b1, hold_d, hold_l}) begin
        nerr++;  $display("FAIL slice_hold: got v=%b %h l=%b want v=1 %h l=%b", m_sv, m_sd, m_sl, hold_d, hold_l);
      end
    end
    hold_pend = m_sv && !ready && !abort;
    hold_d = m_sd;  hold_l = m_sl;
    if (m_sv && ready) begin
      hs_cyc.push_back(cyc);  nvec++;
      if (exp_sl.size() == 0) begin
        nerr++;  $display("FAIL slice_unexpected: got %h want no slice", m_sd);
      end else begin
        es = exp_sl.pop_front();
        if ({m_sd, m_sl} !== {es.d, es.l}) begin
          nerr++;  $display("FAIL slice: got %h last=%b want %h last=%b", m_sd, m_sl, es.d, es.l);
        end
      end
      if (m_sl && auto_res) pend = 1'b1;
    end
    if (m_wr) begin
      wr_cyc = cyc;  wr_cnt++;  nvec++;
      if (exp_wr.size() == 0) begin
        nerr++;  $display("FAIL wr_unexpected: got %h/%h want no write", m_wa, m_wd);
      end else begin
        ew = exp_wr.pop_front();
        if ({m_wa, m_wd} !== ew) begin
          nerr++;  $display("FAIL wr: got %h/%h want %h/%h", m_wa, m_wd, ew[31:24], ew[23:0]);
        end
      end
    end
    if (m_done) begin
      done_cnt++;  done_cyc = cyc;
    end
  end

  task automatic push_row(input logic [AW-1:0] a, input logic [AW-1:0] row, input logic [23:0] r);
    logic [191:0] w;
    sl_t e;
    w = pat(a);
    exp_addr.push_back(a);
    for (int j = 0; j < 4; j++) begin
      e.d = w[191 - 48*j -: 48];
      e.l = (j == 3);
      exp_sl.push_back(e);
    end
    exp_wr.push_back({row, r});
    res_tx.push_back(r);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(posedge clk); #1;
    base = b;  num = n;  start = 1'b1;
    @(posedge clk);
    t0 = cyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int d0;
    d0 = done_cnt;  ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({m_all, busy2, done2, err2} !== '0) begin
      nerr++;  $display("FAIL reset_outputs: got %h want 0", {m_all, busy2, done2, err2});
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    bit ok;
    hs_cyc.delete();  lat_obs.delete();
    push_row(8'h10, 8'h00, 24'h00ABCD);
    do_start(8'h10, 8'd1);
    @(negedge clk);
    nvec++;
    if (m_busy !== 1'b1) begin nerr++; $display("FAIL single_busy: got %b want 1", m_busy); end
    wait_done(40, ok);
    nvec++;
    if (!ok) begin nerr++; $display("FAIL single_timeout: got no done want done"); end
    nvec++;
    if (rd_cyc != t0 + 1) begin nerr++; $display("FAIL single_rd_cycle: got %0d want %0d", rd_cyc - t0, 1); end
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (hs_cyc.size() > 0) ? hs_cyc.pop_front() : -1;
      nvec++;
      if (c != t0 + 3 + i) begin nerr++; $display("FAIL single_slice_cycle: got %0d want %0d", c - t0, 3 + i); end
    end
    nvec++;
    if (wr_cyc != t0 + 8) begin nerr++; $display("FAIL single_wr_cycle: got %0d want 8", wr_cyc - t0); end
    nvec++;
    if (done_cyc != t0 + 9) begin nerr++; $display("FAIL single_done_cycle: got %0d want 9", done_cyc - t0); end
    nvec++;
    if (lat_obs.size() != 1 || lat_obs[0] != 2) begin nerr++; $display("FAIL single_latency: got %0d entries want one of 2", lat_obs.size()); end
    @(negedge clk);
    nvec++;
    if ({m_busy, m_done} !== 2'b00) begin nerr++; $display("FAIL single_idle_after: got %b want 00", {m_busy, m_done}); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int h0;
    hs_cyc.delete();
    h0 = hold_cnt;
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    push_row(8'h40, 8'h00, 24'h123456);
    do_start(8'h40, 8'd1);
    wait_done(60, ok);
    nvec++;
    if (!ok) begin nerr++; $display("FAIL bp_timeout: got no done want done"); end
    nvec++;
    if (hs_cyc.size() != 4) begin nerr++; $display("FAIL bp_handshakes: got %0d want 4", hs_cyc.size()); end
    nvec++;
    if (hold_cnt - h0 != 3) begin nerr++; $display("FAIL bp_hold_cycles: got %0d want 3", hold_cnt - h0); end
  endtask

  task automatic test_wrap;
    bit ok;
    int d0, w0;
    sel = 1'b1;
    lat_obs.delete();
    d0 = done_cnt;  w0 = wr_cnt;
    push_row(8'hFE, 8'h00, 24'hC00000);
    push_row(8'hFF, 8'h01, 24'hC00001);
    push_row(8'h00, 8'h02, 24'hC00002);
    do_start(8'hFE, 8'd3);
    wait_done(80, ok);
    repeat (4) @(posedge clk);
    nvec++;
    if (!ok) begin nerr++; $display("FAIL wrap_timeout: got no done want done"); end
    nvec++;
    if (done_cnt - d0 != 1) begin nerr++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - d0); end
    nvec++;
    if (wr_cnt - w0 != 3) begin nerr++; $display("FAIL wrap_writes: got %0d want 3", wr_cnt - w0); end
    nvec++;
    if (lat_obs.size() != 3) begin nerr++; $display("FAIL wrap_rows_issued: got %0d want 3", lat_obs.size()); end
    foreach (lat_obs[i]) begin
      nvec++;
      if (lat_obs[i] != 3) begin nerr++; $display("FAIL wrap_latency: got %0d want 3", lat_obs[i]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_zero_rows;
    bit ok;
    int r0;
    r0 = rd_cnt;
    do_start(8'h33, 8'd0);
    wait_done(5, ok);
    repeat (3) @(posedge clk);
    nvec++;
    if (!ok || done_cyc != t0 + 1) begin nerr++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc - t0); end
    nvec++;
    if (rd_cnt != r0) begin nerr++; $display("FAIL zero_no_read: got %0d reads want 0", rd_cnt - r0); end
  endtask

  task automatic test_start_busy;
    bit ok;
    int d0, w0;
    d0 = done_cnt;  w0 = wr_cnt;
    push_row(8'h20, 8'h00, 24'h0A0A0A);
    push_row(8'h21, 8'h01, 24'h0B0B0B);
    do_start(8'h20, 8'd2);
    repeat (3) @(posedge clk);
    #1 base = 8'h80;  num = 8'd5;  start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, ok);
    repeat (12) @(posedge clk);
    nvec++;
    if (!ok || done_cnt - d0 != 1) begin nerr++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); end
    nvec++;
    if (wr_cnt - w0 != 2) begin nerr++; $display("FAIL busy_start_rows: got %0d want 2", wr_cnt - w0); end
  endtask

  task automatic test_abort;
    bit ok;
    int d0, w0;
    sl_t e;
    logic [191:0] w;
    d0 = done_cnt;  w0 = wr_cnt;
    rdy_q = '{1'b1, 1'b1, 1'b0};
    w = pat(8'h50);
    exp_addr.push_back(8'h50);
    for (int j = 0; j < 2; j++) begin
      e.d = w[191 - 48*j -: 48];  e.l = 1'b0;
      exp_sl.push_back(e);
    end
    do_start(8'h50, 8'd1);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    nvec++;
    if ({m_sv, m_busy} !== 2'b00) begin nerr++; $display("FAIL abort_drop: got sv/busy %b want 00", {m_sv, m_busy}); end
    repeat (10) @(posedge clk);
    nvec++;
    if (done_cnt != d0 || wr_cnt != w0) begin nerr++; $display("FAIL abort_quiet: got done %0d wr %0d want 0 0", done_cnt - d0, wr_cnt - w0); end
    nvec++;
    if (exp_sl.size() != 0) begin nerr++; $display("FAIL abort_slices: got %0d pending want 0", exp_sl.size()); end
    push_row(8'h60, 8'h00, 24'h0FACE0);
    do_start(8'h60, 8'd1);
    wait_done(40, ok);
    nvec++;
    if (!ok || wr_cnt - w0 != 1) begin nerr++; $display("FAIL abort_restart: got %0d writes want 1", wr_cnt - w0); end
  endtask

  task automatic test_error;
    bit ok;
    push_row(8'h70, 8'h00, 24'h777777);
    do_start(8'h70, 8'd1);
    res_man_cyc = t0 + 2;
    @(negedge clk);
    nvec++;
    if (m_err !== 1'b0) begin nerr++; $display("FAIL err_clear_on_start: got %b want 0", m_err); end
    wait_done(40, ok);
    nvec++;
    if (!ok) begin nerr++; $display("FAIL err_timeout: got no done want done"); end
    @(negedge clk);
    nvec++;
    if (m_err !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b want 1", m_err); end
    res_man_cyc = -1;
  endtask

  task automatic test_reset_mid;
    auto_res = 1'b0;
    push_row(8'h90, 8'h00, 24'h999999);
    void'(exp_wr.pop_back());
    void'(res_tx.pop_back());
    do_start(8'h90, 8'd1);
    res_man_cyc = t0 + 2;
    repeat (8) @(posedge clk);
    #1;
    nvec++;
    if ({m_busy, m_err} !== 2'b11) begin nerr++; $display("FAIL rst_mid_before: got busy/err %b want 11", {m_busy, m_err}); end
    rst = 1'b1;
    #1;
    nvec++;
    if (m_all !== '0) begin nerr++; $display("FAIL rst_mid_outputs: got %h want 0", m_all); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    res_man_cyc = -1;
    auto_res = 1'b1;
    nvec++;
    if (exp_addr.size() + exp_sl.size() + exp_wr.size() != 0) begin
      nerr++;  $display("FAIL rst_mid_pending: got %0d outstanding want 0", exp_addr.size() + exp_sl.size() + exp_wr.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_zero_rows();
    test_start_busy();
    test_abort();
    test_error();
    test_reset_mid();
    nvec++;
    if (exp_addr.size() + exp_sl.size() + exp_wr.size() != 0) begin
      nerr++;  $display("FAIL final_pending: got %0d outstanding want 0", exp_addr.size() + exp_sl.size() + exp_wr.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
